// File: rtl/core_step_controller_if.sv
// Bundles the board-side controls and the Core-side step/PC/status signals of the step controller.
interface core_step_controller_if #(
    parameter int XLEN = 64
);
    logic            step_btn;
    logic            run_en;
    logic            bp_en;
    logic [XLEN-1:0] bp_addr;
    logic [XLEN-1:0] pc;
    logic            clr_count;
    logic            step;
    logic            running;
    logic            at_break;
    logic [XLEN-1:0] step_count;
    logic [2:0]      state_dbg;

    modport master (
        output step_btn, run_en, bp_en, bp_addr, pc, clr_count,
        input  step, running, at_break, step_count, state_dbg
    );

    modport slave (
        input  step_btn, run_en, bp_en, bp_addr, pc, clr_count,
        output step, running, at_break, step_count, state_dbg
    );
endinterface

// File: rtl/core_step_controller.sv
// Generates the Core step enable: halted, debounced single-step, free-run and PC breakpoint halt.
// Also keeps a step counter and status flags for the debug display.
module core_step_controller #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int XLEN            = 64
) (
    input  logic                 clk,
    input  logic                 areset,
    core_step_controller_if.slave io
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [2:0] {
        S_HALT    = 3'd0,
        S_STEP    = 3'd1,
        S_RUN     = 3'd2,
        S_BREAK   = 3'd3,
        S_STEPOUT = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic [CW-1:0]   db_cnt_q, db_cnt_d;
    logic            btn_db_q, btn_db_d;
    logic            btn_prev_q;
    logic [XLEN-1:0] count_q, count_d;
    logic            running_q, running_d;
    logic            at_break_q, at_break_d;
    logic            step_req;
    logic            bp_hit;
    logic            step_c;

    assign step_req = btn_db_q && !btn_prev_q;
    assign bp_hit   = io.bp_en && (io.pc == io.bp_addr);
    // A breakpointed instruction must never execute, so RUN gates on bp_hit combinationally.
    assign step_c   = (state_q == S_STEP) || (state_q == S_STEPOUT) ||
                      ((state_q == S_RUN) && io.run_en && !bp_hit);

    always_comb begin
        db_cnt_d = '0;
        btn_db_d = btn_db_q;
        if (sync2_q != btn_db_q) begin
            if (db_cnt_q == DB_MAX) begin
                btn_db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HALT: begin
                if (step_req)         state_d = S_STEP;
                else if (io.run_en)   state_d = S_RUN;
            end
            S_STEP:                   state_d = S_HALT;
            S_RUN: begin
                if (!io.run_en)       state_d = S_HALT;
                else if (bp_hit)      state_d = S_BREAK;
            end
            S_BREAK: begin
                if (!io.run_en)       state_d = S_HALT;
                else if (step_req)    state_d = S_STEPOUT;
            end
            S_STEPOUT:                state_d = io.run_en ? S_RUN : S_HALT;
            default:                  state_d = S_HALT;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (io.clr_count)  count_d = '0;
        else if (step_c)   count_d = count_q + XLEN'(1);
        running_d  = (state_d == S_RUN);
        at_break_d = (state_d == S_BREAK);
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q    <= S_HALT;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_cnt_q   <= '0;
            btn_db_q   <= 1'b0;
            btn_prev_q <= 1'b0;
            count_q    <= '0;
            running_q  <= 1'b0;
            at_break_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= io.step_btn;
            sync2_q    <= sync1_q;
            db_cnt_q   <= db_cnt_d;
            btn_db_q   <= btn_db_d;
            btn_prev_q <= btn_db_q;
            count_q    <= count_d;
            running_q  <= running_d;
            at_break_q <= at_break_d;
        end
    end

    assign io.step       = step_c;
    assign io.running    = running_q;
    assign io.at_break   = at_break_q;
    assign io.step_count = count_q;
    assign io.state_dbg  = state_q;
endmodule

// File: tb/tb_core_step_controller.sv
// Directed bench for core_step_controller with a simple Core model (pc += 4 per step).
module tb_core_step_controller;
    logic clk;
    logic areset;
    int   n_tests;
    int   n_fail;
    int   steps_seen;

    core_step_controller_if #(.XLEN(64)) bus0 ();
    core_step_controller_if #(.XLEN(4))  bus1 ();

    core_step_controller #(.DEBOUNCE_CYCLES(4), .XLEN(64)) dut (
        .clk    (clk),
        .areset (areset),
        .io     (bus0)
    );

    core_step_controller #(.DEBOUNCE_CYCLES(4), .XLEN(4)) dut_small (
        .clk    (clk),
        .areset (areset),
        .io     (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge areset) begin
        if (areset)         bus0.pc <= 64'h8000_0000;
        else if (bus0.step) bus0.pc <= bus0.pc + 64'd4;
    end

    always @(negedge clk) begin
        if (areset)         steps_seen = 0;
        else if (bus0.step) steps_seen = steps_seen + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int max_cycles, input string tag);
        int k;
        k = 0;
        while (bus0.state_dbg !== s && k < max_cycles) begin
            @(negedge clk);
            k++;
        end
        check(tag, {61'd0, bus0.state_dbg}, {61'd0, s});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        areset  = 1'b1;
        bus0.step_btn  = 1'b0;
        bus0.run_en    = 1'b0;
        bus0.bp_en     = 1'b0;
        bus0.bp_addr   = 64'd0;
        bus0.clr_count = 1'b0;
        bus1.step_btn  = 1'b0;
        bus1.run_en    = 1'b1;
        bus1.bp_en     = 1'b0;
        bus1.bp_addr   = 4'd0;
        bus1.pc        = 4'd0;
        bus1.clr_count = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_step",     {63'd0, bus0.step},     64'd0);
        check("rst_running",  {63'd0, bus0.running},  64'd0);
        check("rst_count",    bus0.step_count,        64'd0);
        check("rst_state",    {61'd0, bus0.state_dbg}, 64'd0);
        areset = 1'b0;

        // short press and a clean long press from HALT
        repeat (3) @(negedge clk);
        bus0.step_btn = 1'b1;
        repeat (3) @(negedge clk);
        bus0.step_btn = 1'b0;
        repeat (12) @(negedge clk);
        check("t2_short_count", bus0.step_count, 64'd0);
        bus0.step_btn = 1'b1;
        repeat (12) @(negedge clk);
        bus0.step_btn = 1'b0;
        @(negedge clk);
        bus0.step_btn = 1'b1;
        repeat (2) @(negedge clk);
        bus0.step_btn = 1'b0;
        repeat (20) @(negedge clk);
        check("t2_count", bus0.step_count, 64'd1);
        check("t2_pc",    bus0.pc,         64'h8000_0004);
        check("t2_seen",  64'(steps_seen), 64'd1);
        check("t2_state", {61'd0, bus0.state_dbg}, 64'd0);

        // free run for 20 steps
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        bus0.run_en = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        bus0.run_en = 1'b0;
        #1;
        check("t3_step_fall", {63'd0, bus0.step}, 64'd0);
        check("t3_count",     bus0.step_count,    64'd20);
        check("t3_pc",        bus0.pc,            64'h8000_0050);
        repeat (2) @(negedge clk);
        check("t3_count_hold", bus0.step_count,   64'd20);
        check("t3_state",     {61'd0, bus0.state_dbg}, 64'd0);

        // breakpoint from reset
        areset       = 1'b1;
        bus0.bp_en   = 1'b1;
        bus0.bp_addr = 64'h8000_0010;
        bus0.run_en  = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        repeat (12) @(negedge clk);
        check("t4_at_break", {63'd0, bus0.at_break}, 64'd1);
        check("t4_running",  {63'd0, bus0.running},  64'd0);
        check("t4_step",     {63'd0, bus0.step},     64'd0);
        check("t4_pc",       bus0.pc,                64'h8000_0010);
        check("t4_count",    bus0.step_count,        64'd4);
        check("t4_state",    {61'd0, bus0.state_dbg}, 64'd3);

        // step out of the breakpoint, then RUN resumes
        bus0.step_btn = 1'b1;
        wait_state(3'd4, 30, "t5_stepout_reached");
        check("t5_stepout_step", {63'd0, bus0.step}, 64'd1);
        check("t5_stepout_pc",   bus0.pc,            64'h8000_0010);
        @(negedge clk);
        check("t5_pc",       bus0.pc,                64'h8000_0014);
        check("t5_state",    {61'd0, bus0.state_dbg}, 64'd2);
        check("t5_running",  {63'd0, bus0.running},  64'd1);
        check("t5_at_break", {63'd0, bus0.at_break}, 64'd0);
        check("t5_count",    bus0.step_count,        64'd5);
        bus0.step_btn = 1'b0;

        // synchronous clear while running
        repeat (5) @(negedge clk);
        bus0.clr_count = 1'b1;
        @(negedge clk);
        bus0.clr_count = 1'b0;
        check("t6_clr",    bus0.step_count, 64'd0);
        @(negedge clk);
        check("t6_resume", bus0.step_count, 64'd1);

        // async reset mid-cycle while running
        #2;
        areset = 1'b1;
        #1;
        check("t1_step",     {63'd0, bus0.step},      64'd0);
        check("t1_running",  {63'd0, bus0.running},   64'd0);
        check("t1_at_break", {63'd0, bus0.at_break},  64'd0);
        check("t1_count",    bus0.step_count,         64'd0);
        check("t1_state",    {61'd0, bus0.state_dbg}, 64'd0);
        @(negedge clk);
        areset = 1'b0;

        // counter wrap on the narrow instance
        begin
            int k;
            k = 0;
            while (bus1.step_count !== 4'hF && k < 40) begin
                @(negedge clk);
                k++;
            end
        end
        check("wrap_pre",  {60'd0, bus1.step_count}, 64'd15);
        @(negedge clk);
        check("wrap_zero", {60'd0, bus1.step_count}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
